spn_cu_master: RTL and testbench

//  Initiator side of the spn_if core protocol: the host-facing request engine that drives spn_cu_top.

---
 rtl/spn_cu_master.sv | 190 +++++++++++++++++++
 tb/tb_spn_cu_master.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spn_cu_master.sv
// spn_cu_master: host-facing request engine for the spn_if core.
// Accepts encrypt/decrypt requests, pulses one opcode into the core, waits
// for the matching registered core_valid (or a timeout), and queues
// {op, data, err} responses in a small FIFO with its own valid/ready port.
module spn_cu_master #(
    parameter int unsigned RSP_DEPTH = 4,
    parameter int unsigned TIMEOUT   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_data,
    input  logic [31:0] req_key,
    output logic [1:0]  core_opcode,
    output logic [15:0] core_data_in,
    output logic [31:0] core_key,
    input  logic [1:0]  core_valid,
    input  logic [15:0] core_data_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_op,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output logic [15:0] req_cnt,
    output logic [7:0]  err_cnt
);

    localparam int unsigned PW = $clog2(RSP_DEPTH);
    localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
    localparam int unsigned TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    lat_op;
    logic [15:0]   lat_data;
    logic [31:0]   lat_key;
    logic [TW-1:0] timer;

    logic [18:0]   mem [RSP_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [18:0]   head;

    logic          accept;
    logic          push;
    logic          pop;
    logic [1:0]    push_op;
    logic [15:0]   push_data;
    logic          push_err;

    // Gated with rst_n so the port reads 0 while reset is held.
    assign req_ready    = rst_n && (state == S_IDLE) && (count < CW'(RSP_DEPTH));
    assign busy         = (state != S_IDLE);
    assign core_opcode  = (state == S_ISSUE) ? lat_op : 2'b00;
    assign core_data_in = lat_data;
    assign core_key     = lat_key;

    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign head      = mem[rd_ptr];
    assign {rsp_op, rsp_data, rsp_err} = rsp_valid ? head : '0;

    // Next-state logic and response push decision.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        push      = 1'b0;
        push_op   = lat_op;
        push_data = '0;
        push_err  = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    accept = 1'b1;
                    if (req_op == 2'b01 || req_op == 2'b10) begin
                        state_nxt = S_ISSUE;
                    end else begin
                        push     = 1'b1;
                        push_op  = req_op;
                        push_err = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (core_valid == lat_op) begin
                    push      = 1'b1;
                    push_data = core_data_out;
                    state_nxt = S_IDLE;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    push      = 1'b1;
                    push_err  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request latch: core inputs change only when a request is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lat_op   <= '0;
            lat_data <= '0;
            lat_key  <= '0;
        end else if (accept) begin
            lat_op   <= req_op;
            lat_data <= req_data;
            lat_key  <= req_key;
        end
    end

    // WAIT cycle counter; cleared in every other state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (state == S_WAIT) begin
            timer <= timer + 1'b1;
        end else begin
            timer <= '0;
        end
    end

    // Response FIFO storage; validity is tracked by count, so no reset needed.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= {push_op, push_data, push_err};
        end
    end

    // Response FIFO pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Accepted-request counter (wraps) and error-response counter (saturates).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_cnt <= '0;
            err_cnt <= '0;
        end else begin
            if (accept) begin
                req_cnt <= req_cnt + 1'b1;
            end
            if (push && push_err && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spn_cu_master.sv
// Bench for spn_cu_master: a behavioural core stand-in, a queue-based
// response model and a per-cycle compare process, plus directed scenarios.
module tb_spn_cu_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_data;
    logic [31:0] req_key;
    logic [1:0]  core_opcode;
    logic [15:0] core_data_in;
    logic [31:0] core_key;
    logic [1:0]  core_valid;
    logic [15:0] core_data_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_op;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic [15:0] req_cnt;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    spn_cu_master #(.RSP_DEPTH(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_data(req_data), .req_key(req_key),
        .core_opcode(core_opcode), .core_data_in(core_data_in), .core_key(core_key),
        .core_valid(core_valid), .core_data_out(core_data_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .req_cnt(req_cnt), .err_cnt(err_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Stand-in transform for the real cipher core; any fixed function works.
    function automatic logic [15:0] core_fn(input logic [1:0] op, input logic [15:0] d,
                                            input logic [31:0] k);
        if (op == 2'b01) return ({d[7:0], d[15:8]} ^ k[15:0]) + k[31:16];
        return (d - k[31:16]) ^ k[15:0];
    endfunction

    // Core stand-in: 0 = echoes opcode one cycle later, 1 = silent, 2 = wrong opcode.
    int stub_mode = 0;
    always @(posedge clk) begin
        if (!rst_n) begin
            core_valid    <= 2'b00;
            core_data_out <= 16'h0000;
        end else begin
            core_data_out <= core_fn(core_opcode, core_data_in, core_key);
            case (stub_mode)
                0:       core_valid <= core_opcode;
                1:       core_valid <= 2'b00;
                default: core_valid <= (core_opcode == 2'b00) ? 2'b00 : ~core_opcode;
            endcase
        end
    end

    // Response model: each accepted request predicts its response up front.
    typedef struct packed {
        logic [1:0]  op;
        logic [15:0] data;
        logic        err;
    } rsp_t;

    rsp_t        exp_q[$];
    int          m_req_cnt = 0;
    int          legal_issues = 0;
    logic [1:0]  m_op = 2'b00;
    logic [15:0] m_data = 16'h0;
    logic [31:0] m_key = 32'h0;

    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_req_cnt <= 0;
        end else begin
            if (rsp_valid && rsp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (req_valid && req_ready) begin
                m_req_cnt <= m_req_cnt + 1;
                m_op      <= req_op;
                m_data    <= req_data;
                m_key     <= req_key;
                if (req_op == 2'b01 || req_op == 2'b10) begin
                    legal_issues <= legal_issues + 1;
                    if (stub_mode == 0)
                        exp_q.push_back('{req_op, core_fn(req_op, req_data, req_key), 1'b0});
                    else
                        exp_q.push_back('{req_op, 16'h0000, 1'b1});
                end else begin
                    exp_q.push_back('{req_op, 16'h0000, 1'b1});
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    int   pulses = 0;
    logic prev_nz = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            check("req_cnt", req_cnt, 64'(m_req_cnt[15:0]));
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got op=%0h data=%0h err=%0b expected no response",
                             rsp_op, rsp_data, rsp_err);
                end else begin
                    check("rsp_op", rsp_op, exp_q[0].op);
                    check("rsp_data", rsp_data, exp_q[0].data);
                    check("rsp_err", rsp_err, exp_q[0].err);
                end
            end
            if (core_opcode != 2'b00) begin
                pulses++;
                check("core_opcode", core_opcode, m_op);
                check("core_data_in", core_data_in, m_data);
                check("core_key", core_key, m_key);
                check("pulse_single", prev_nz, 0);
            end
            prev_nz = (core_opcode != 2'b00);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [1:0] op, input logic [15:0] d, input logic [31:0] k);
        bit done = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
        req_key   = k;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready) begin
                done = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got req_ready 0 for 40 cycles expected 1");
        end
    endtask

    task automatic wait_idle(output int cycles);
        bit done = 0;
        cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1;
                break;
            end
            cycles++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy 1 for 40 cycles expected 0");
        end
    endtask

    // Exact-latency transaction with a hand-computed expected result.
    task automatic run_literal(input logic [1:0] op, input logic [15:0] d, input logic [31:0] k,
                               input logic [15:0] exp_data);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
        req_key   = k;
        @(negedge clk);
        check("lit_c0_req_ready", req_ready, 1);
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        check("lit_c1_opcode", core_opcode, op);
        check("lit_c1_busy", busy, 1);
        next_cycle();
        @(negedge clk);
        check("lit_c2_opcode", core_opcode, 0);
        check("lit_c2_rsp_valid", rsp_valid, 0);
        next_cycle();
        @(negedge clk);
        check("lit_c3_rsp_valid", rsp_valid, 1);
        check("lit_c3_rsp_op", rsp_op, op);
        check("lit_c3_rsp_err", rsp_err, 0);
        check("lit_c3_rsp_data", rsp_data, exp_data);
        next_cycle();
        @(negedge clk);
        check("lit_c4_rsp_valid", rsp_valid, 0);
        check("lit_c4_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        int cyc;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_data  = 16'h0;
        req_key   = 32'h0;
        rsp_ready = 1'b1;
        repeat (3) next_cycle();
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_req_cnt", req_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_core_opcode", core_opcode, 0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("release_req_ready", req_ready, 1);
        next_cycle();

        // Encrypt and decrypt with exact latency.
        run_literal(2'b01, 16'h1234, 32'hA1B2C3D4, 16'h9978);
        next_cycle();
        run_literal(2'b10, 16'hBEEF, 32'h0F0F0F0F, 16'hA0EF);
        next_cycle();

        // Illegal opcodes: error responses, core never driven.
        send_req(2'b11, 16'hDEAD, 32'h1);
        send_req(2'b00, 16'hBEEF, 32'h2);
        repeat (3) next_cycle();
        @(negedge clk);
        check("illegal_err_cnt", err_cnt, 2);
        check("illegal_pulses", pulses, 2);
        check("illegal_rsp_drained", rsp_valid, 0);
        next_cycle();

        // Timeout with a silent core, then with a mismatched core_valid.
        stub_mode = 1;
        send_req(2'b01, 16'h0F0F, 32'h11112222);
        wait_idle(cyc);
        check("timeout_busy_cycles", cyc, 9);
        check("timeout_req_ready", req_ready, 1);
        check("timeout_err_cnt", err_cnt, 3);
        next_cycle();
        stub_mode = 2;
        send_req(2'b10, 16'hF0F0, 32'h33334444);
        wait_idle(cyc);
        check("mismatch_busy_cycles", cyc, 9);
        check("mismatch_err_cnt", err_cnt, 4);
        next_cycle();
        stub_mode = 0;
        repeat (2) next_cycle();

        // Backpressure: fill the FIFO, stall a fifth request, pop, then drain.
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_req(2'b01, 16'h1000 + 16'(i), 32'hCAFE0000 + 32'(i));
        wait_idle(cyc);
        check("full_req_ready", req_ready, 0);
        check("full_rsp_valid", rsp_valid, 1);
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_data  = 16'h1004;
        req_key   = 32'hCAFE0004;
        repeat (3) next_cycle();
        @(negedge clk);
        check("stall_req_cnt", req_cnt, 10);
        check("stall_req_ready", req_ready, 0);
        rsp_ready = 1'b1;
        next_cycle();
        rsp_ready = 1'b0;
        send_req(2'b01, 16'h1004, 32'hCAFE0004);
        next_cycle();
        rsp_ready = 1'b1;
        repeat (8) next_cycle();
        @(negedge clk);
        check("drain_rsp_valid", rsp_valid, 0);
        check("drain_model_empty", exp_q.size(), 0);
        check("drain_req_cnt", req_cnt, 11);
        next_cycle();

        // Reset while waiting on the core: in-flight op is dropped.
        stub_mode = 1;
        send_req(2'b01, 16'h5555, 32'h12345678);
        repeat (2) next_cycle();
        rst_n = 1'b0;
        repeat (2) next_cycle();
        @(negedge clk);
        check("midrst_req_ready", req_ready, 0);
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_req_cnt", req_cnt, 0);
        check("midrst_err_cnt", err_cnt, 0);
        check("midrst_core_opcode", core_opcode, 0);
        next_cycle();
        rst_n = 1'b1;
        stub_mode = 0;
        repeat (12) next_cycle();
        @(negedge clk);
        check("postrst_rsp_valid", rsp_valid, 0);
        check("postrst_err_cnt", err_cnt, 0);
        next_cycle();
        run_literal(2'b01, 16'h1234, 32'hA1B2C3D4, 16'h9978);
        @(negedge clk);
        check("postrst_req_cnt", req_cnt, 1);
        check("final_pulses", pulses, legal_issues);
        check("final_model_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
